// File: rtl/flash_read_arbiter_if.sv
// Bundles the two requester ports and the Avalon-MM flash read port of flash_read_arbiter.
// master is the arbiter's view; slave is the view of the requesters and flash controller around it.
interface flash_read_arbiter_if #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic              flash_read;
    logic [ADDR_W-1:0] flash_address;
    logic [3:0]        flash_byteenable;
    logic              flash_waitrequest;
    logic              flash_readdatavalid;
    logic [DATA_W-1:0] flash_readdata;

    modport master (
        input  req0, req1, addr0, addr1,
        output done0, done1, rdata, err, busy,
        output flash_read, flash_address, flash_byteenable,
        input  flash_waitrequest, flash_readdatavalid, flash_readdata
    );

    modport slave (
        output req0, req1, addr0, addr1,
        input  done0, done1, rdata, err, busy,
        input  flash_read, flash_address, flash_byteenable,
        output flash_waitrequest, flash_readdatavalid, flash_readdata
    );
endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing the flash Avalon-MM read port between two requesters,
// one read in flight at a time, with a readdatavalid timeout that reports err.
module flash_read_arbiter #(
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    flash_read_arbiter_if.master bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_read;
    logic [ADDR_W-1:0] r_addr;
    logic              r_grant;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_done0;
    logic              r_done1;
    logic              r_busy;

    state_t            w_state;
    logic              w_read;
    logic [ADDR_W-1:0] w_addr;
    logic              w_grant;
    logic              w_last_grant;
    logic [CNT_W-1:0]  w_cnt;
    logic [DATA_W-1:0] w_rdata;
    logic              w_err;
    logic              w_done0;
    logic              w_done1;
    logic              w_busy;
    logic              w_win;

    // With both requesting, the one not granted last time wins.
    assign w_win = (bus.req0 && bus.req1) ? ~r_last_grant : bus.req1;

    // Next-state and next-output logic.
    always_comb begin
        w_state      = r_state;
        w_read       = 1'b0;
        w_addr       = r_addr;
        w_grant      = r_grant;
        w_last_grant = r_last_grant;
        w_cnt        = r_cnt;
        w_rdata      = r_rdata;
        w_err        = r_err;
        w_done0      = 1'b0;
        w_done1      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_state      = S_ISSUE;
                    w_read       = 1'b1;
                    w_grant      = w_win;
                    w_last_grant = w_win;
                    w_addr       = w_win ? bus.addr1 : bus.addr0;
                end
            end
            S_ISSUE: begin
                if (bus.flash_waitrequest) begin
                    w_read = 1'b1;
                end else begin
                    w_cnt   = '0;
                    w_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.flash_readdatavalid) begin
                    w_rdata = bus.flash_readdata;
                    w_err   = 1'b0;
                    w_state = S_RESPOND;
                    w_done0 = ~r_grant;
                    w_done1 = r_grant;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_rdata = '0;
                    w_err   = 1'b1;
                    w_state = S_RESPOND;
                    w_done0 = ~r_grant;
                    w_done1 = r_grant;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_RESPOND: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    // State and registered outputs; reset abandons any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_read       <= 1'b0;
            r_addr       <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_read       <= w_read;
            r_addr       <= w_addr;
            r_grant      <= w_grant;
            r_last_grant <= w_last_grant;
            r_cnt        <= w_cnt;
            r_rdata      <= w_rdata;
            r_err        <= w_err;
            r_done0      <= w_done0;
            r_done1      <= w_done1;
            r_busy       <= w_busy;
        end
    end

    assign bus.done0            = r_done0;
    assign bus.done1            = r_done1;
    assign bus.rdata            = r_rdata;
    assign bus.err              = r_err;
    assign bus.busy             = r_busy;
    assign bus.flash_read       = r_read;
    assign bus.flash_address    = r_addr;
    assign bus.flash_byteenable = 4'hF;
endmodule
